// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port between ALU and load
// writeback, with a pending-write scoreboard that flags read hazards.
module regfile_write_arbiter #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [4:0]       req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             reserve_valid,
    input  logic [4:0]       reserve_addr,
    input  logic [4:0]       select_a,
    input  logic [4:0]       select_b,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic             rf_write,
    output logic [4:0]       rf_address,
    output logic [WIDTH-1:0] rf_data,
    output logic [31:0]      pending
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic             last_grant;
    logic             xfer;
    logic             xfer_write;
    logic [4:0]       xfer_addr;
    logic [WIDTH-1:0] xfer_data;
    logic [31:0]      pending_next;

    // last_grant=1 means req1 won most recently, so req0 takes the next contention
    always_comb begin
        req0_ready = req0_valid && (!req1_valid || last_grant);
        req1_ready = req1_valid && (!req0_valid || !last_grant);
        xfer       = req0_ready || req1_ready;
        xfer_addr  = req0_ready ? req0_addr : req1_addr;
        xfer_data  = req0_ready ? req0_data : req1_data;
        xfer_write = xfer && xfer_addr != ZR;
    end

    // clear first, then set, so a same-edge reserve of the written register wins
    always_comb begin
        pending_next = pending;
        if (xfer)
            pending_next[xfer_addr] = 1'b0;
        if (reserve_valid)
            pending_next[reserve_addr] = 1'b1;
        pending_next[ZR] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            rf_write   <= 1'b0;
            rf_address <= '0;
            rf_data    <= '0;
            pending    <= '0;
        end else begin
            rf_write <= xfer_write;
            pending  <= pending_next;
            if (xfer)
                last_grant <= req1_ready;
            if (xfer_write) begin
                rf_address <= xfer_addr;
                rf_data    <= xfer_data;
            end
        end
    end

    // the in-flight write still counts as pending until the register file captures it
    always_comb begin
        hazard_a = (pending[select_a] || (rf_write && rf_address == select_a)) && select_a != ZR;
        hazard_b = (pending[select_b] || (rf_write && rf_address == select_b)) && select_b != ZR;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic checked against a
// behavioural model of grants, write outputs, scoreboard and hazards.
module tb_regfile_write_arbiter;
    localparam int W = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid, req1_valid, reserve_valid;
    logic [4:0]    req0_addr, req1_addr, reserve_addr, select_a, select_b, rf_address;
    logic [W-1:0]  req0_data, req1_data, rf_data;
    logic          req0_ready, req1_ready, hazard_a, hazard_b, rf_write;
    logic [31:0]   pending;
    logic [W-1:0]  regs [32];
    int            checks = 0;
    int            errors = 0;

    int            m_last;
    bit [31:0]     m_pend;
    bit            m_wr, m_g0, m_g1;
    int            m_addr;
    logic [W-1:0]  m_data;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.WIDTH(W), .ZERO_REG(31)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .select_a(select_a), .select_b(select_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .rf_write(rf_write), .rf_address(rf_address), .rf_data(rf_data), .pending(pending)
    );

    always @(posedge clock)
        if (rf_write)
            regs[rf_address] <= rf_data;

    task automatic model_reset();
        m_last = 1; m_pend = '0; m_wr = 0; m_addr = 0; m_data = '0; m_g0 = 0; m_g1 = 0;
    endtask

    task automatic exp_grants(output bit g0, output bit g1);
        g0 = 0; g1 = 0;
        if (req0_valid && req1_valid) begin
            if (m_last == 0) g1 = 1; else g0 = 1;
        end else begin
            g0 = req0_valid; g1 = req1_valid;
        end
    endtask

    function automatic bit exp_hazard(input logic [4:0] sel);
        return sel != 31 && (m_pend[sel] || (m_wr && m_addr == int'(sel)));
    endfunction

    task automatic model_edge();
        int a;
        exp_grants(m_g0, m_g1);
        m_wr = 0;
        if (m_g0 || m_g1) begin
            a = m_g0 ? int'(req0_addr) : int'(req1_addr);
            m_last = m_g0 ? 0 : 1;
            m_pend[a] = 0;
            if (a != 31) begin
                m_wr = 1; m_addr = a; m_data = m_g0 ? req0_data : req1_data;
            end
        end
        if (reserve_valid && reserve_addr != 31)
            m_pend[reserve_addr] = 1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        req0_valid = 0; req1_valid = 0; reserve_valid = 0;
    endtask

    task automatic test_reset();
        model_reset();
        req0_valid = 1'($urandom); req1_valid = 1'($urandom); reserve_valid = 1'($urandom);
        req0_addr = 5'($urandom); req1_addr = 5'($urandom); reserve_addr = 5'($urandom);
        req0_data = {$urandom, $urandom}; req1_data = {$urandom, $urandom};
        select_a = 5'($urandom); select_b = 5'($urandom);
        #7;
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write got %b want 0", rf_write); end
        checks++; if (rf_address !== 5'd0) begin errors++; $display("FAIL reset_rf_address got %0d want 0", rf_address); end
        checks++; if (rf_data !== '0) begin errors++; $display("FAIL reset_rf_data got %h want 0", rf_data); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
        checks++; if ({hazard_a, hazard_b} !== 2'b00) begin errors++; $display("FAIL reset_hazard got %b want 00", {hazard_a, hazard_b}); end
        @(negedge clock);
        reset = 1;
        idle();
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL first_contention got %b want 10", {req0_ready, req1_ready}); end
    endtask

    task automatic test_contention();
        logic [W-1:0] d0, d1;
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
        req0_valid = 1; req0_addr = 3; req0_data = d0;
        req1_valid = 1; req1_addr = 5; req1_data = d1;
        select_a = 0; select_b = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== (k % 2 == 0 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant%0d got %b", k, {req0_ready, req1_ready}); end
            tick();
            if (k == 3) idle();
            checks++; if (rf_write !== 1'b1 || rf_address !== (k % 2 == 0 ? 5'd3 : 5'd5)) begin errors++; $display("FAIL contention_write%0d got %b/%0d", k, rf_write, rf_address); end
            checks++; if (rf_data !== (k % 2 == 0 ? d0 : d1)) begin errors++; $display("FAIL contention_data%0d got %h", k, rf_data); end
        end
        tick();
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL contention_idle got %b want 0", rf_write); end
    endtask

    task automatic test_latency();
        req1_valid = 1; req1_addr = 7; req1_data = 64'hDEADBEEF00000001;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL latency_grant got %b want 01", {req0_ready, req1_ready}); end
        tick();
        idle();
        checks++; if (rf_write !== 1'b1 || rf_address !== 5'd7 || rf_data !== 64'hDEADBEEF00000001) begin errors++; $display("FAIL latency_write got %b/%0d/%h", rf_write, rf_address, rf_data); end
        tick();
        checks++; if (regs[7] !== 64'hDEADBEEF00000001 || rf_write !== 1'b0) begin errors++; $display("FAIL latency_regfile got %h/%b", regs[7], rf_write); end
    endtask

    task automatic test_scoreboard();
        select_a = 9;
        reserve_valid = 1; reserve_addr = 9;
        tick();
        reserve_valid = 0;
        checks++; if (pending[9] !== 1'b1 || hazard_a !== 1'b1) begin errors++; $display("FAIL sb_reserve got %b/%b want 1/1", pending[9], hazard_a); end
        req0_valid = 1; req0_addr = 9; req0_data = {$urandom, $urandom};
        tick();
        idle();
        checks++; if (pending[9] !== 1'b0 || rf_write !== 1'b1 || hazard_a !== 1'b1) begin errors++; $display("FAIL sb_inflight got %b/%b/%b want 0/1/1", pending[9], rf_write, hazard_a); end
        tick();
        checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL sb_done got %b want 0", hazard_a); end
    endtask

    task automatic test_boundaries();
        reserve_valid = 1; reserve_addr = 9;
        req0_valid = 1; req0_addr = 9; req0_data = {$urandom, $urandom};
        tick();
        idle();
        checks++; if (pending[9] !== 1'b1 || rf_write !== 1'b1) begin errors++; $display("FAIL same_edge got %b/%b want 1/1", pending[9], rf_write); end
        req1_valid = 1; req1_addr = 9; req1_data = {$urandom, $urandom};
        tick();
        idle();
        reserve_valid = 1; reserve_addr = 31;
        tick();
        idle();
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reserve_zero got %h want 0", pending); end
        req0_valid = 1; req0_addr = 31; req0_data = {$urandom, $urandom};
        select_b = 31;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", req0_ready); end
        tick();
        idle();
        checks++; if (rf_write !== 1'b0 || hazard_b !== 1'b0) begin errors++; $display("FAIL zero_write got %b/%b want 0/0", rf_write, hazard_b); end
    endtask

    task automatic test_random();
        bit g0, g1;
        for (int i = 0; i < 500; i++) begin
            if (!(req0_valid && !m_g0)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_addr = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
                req0_data = {$urandom, $urandom};
            end
            if (!(req1_valid && !m_g1)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr = 5'($urandom_range(0, 15));
                req1_data = {$urandom, $urandom};
            end
            reserve_valid = 1'($urandom);
            reserve_addr = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
            select_a = 5'($urandom_range(0, 15));
            select_b = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
            #1;
            exp_grants(g0, g1);
            checks++; if ({req0_ready, req1_ready} !== {g0, g1}) begin errors++; $display("FAIL rand_grant cyc %0d got %b want %b", i, {req0_ready, req1_ready}, {g0, g1}); end
            checks++; if ({hazard_a, hazard_b} !== {exp_hazard(select_a), exp_hazard(select_b)}) begin errors++; $display("FAIL rand_hazard cyc %0d got %b want %b", i, {hazard_a, hazard_b}, {exp_hazard(select_a), exp_hazard(select_b)}); end
            tick();
            checks++; if (rf_write !== m_wr || int'(rf_address) != m_addr || rf_data !== m_data) begin errors++; $display("FAIL rand_write cyc %0d got %b/%0d/%h want %b/%0d/%h", i, rf_write, rf_address, rf_data, m_wr, m_addr, m_data); end
            checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending cyc %0d got %h want %h", i, pending, m_pend); end
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        reset = 0;
        #1;
        reset = 1;
        model_reset();
        reserve_valid = 1; reserve_addr = 4;
        tick();
        reserve_addr = 9;
        req0_valid = 1; req0_addr = 2; req0_data = {$urandom, $urandom};
        tick();
        idle();
        select_a = 4; select_b = 2;
        #1;
        checks++; if (rf_write !== 1'b1 || pending !== 32'h0000_0210 || {hazard_a, hazard_b} !== 2'b11) begin errors++; $display("FAIL pre_reset got %b/%h/%b want 1/00000210/11", rf_write, pending, {hazard_a, hazard_b}); end
        reset = 0;
        #1;
        checks++; if (rf_write !== 1'b0 || rf_address !== 5'd0 || rf_data !== '0 || pending !== 32'h0) begin errors++; $display("FAIL async_reset got %b/%0d/%h/%h want all 0", rf_write, rf_address, rf_data, pending); end
        checks++; if ({hazard_a, hazard_b} !== 2'b00) begin errors++; $display("FAIL async_hazard got %b want 00", {hazard_a, hazard_b}); end
        #2;
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_latency();
        test_scoreboard();
        test_boundaries();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sequences the single write port of the 32x64 register file (r31 hardwired zero) and shares it between two writeback requesters: req0 = ALU, req1 = memory load.
- Uses round-robin arbitration with valid/ready handshakes and registered write outputs.
- Contains a 32-bit pending-write scoreboard, set at issue and cleared at writeback. It flags read hazards for the two read selects.

Parameters:
- WIDTH, 64, data width of register-file entries and write data.
- ZERO_REG, 31, index of the hardwired-zero register; writes and reservations to it are discarded.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  input  1  ALU writeback request.
- req0_addr  input  5  ALU destination register.
- req0_data  input  WIDTH  ALU result.
- req0_ready  output  1  grant to req0 this cycle (combinational).
- req1_valid  input  1  load writeback request.
- req1_addr  input  5  load destination register.
- req1_data  input  WIDTH  load data.
- req1_ready  output  1  grant to req1 this cycle (combinational).
- reserve_valid  input  1  issue stage marks a destination register pending.
- reserve_addr  input  5  register being reserved.
- select_a  input  5  register-file read select A (observed only).
- select_b  input  5  register-file read select B (observed only).
- hazard_a  output  1  select_a result not yet written.
- hazard_b  output  1  select_b result not yet written.
- rf_write  output  1  drives register-file write.
- rf_address  output  5  drives register-file address.
- rf_data  output  WIDTH  drives register-file data_in.
- pending  output  32  scoreboard state.

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_write=0, rf_address=0, rf_data=0, pending=0.
  - Round-robin pointer last_grant=1, so req0 wins the first contention.
  - Reset mid-transfer drops the in-flight write.
- Arbitration (combinational):
  - Only req0 valid → req0_ready=1. Only req1 valid → req1_ready=1.
  - Both valid → grant the requester that was not last_grant.
  - Never both ready. Ready is 0 when the corresponding valid is 0.
- Transfer: occurs when valid && ready at a rising edge.
  - last_grant updates to the winner; it is unchanged in idle cycles.
  - Requesters hold addr/data stable while valid && !ready.
- Write outputs (registered, latency 1):
  - After a transfer edge, rf_write=1 and rf_address/rf_data = winner's addr/data for exactly one cycle.
  - The register file captures the data on the following edge.
  - With no transfer, rf_write=0 and rf_address/rf_data hold their previous values.
  - Transfer to ZERO_REG: handshake completes but rf_write stays 0.
  - Back-to-back transfers give one write per cycle, with no bubble.
- Scoreboard, per edge:
  - reserve_valid sets pending[reserve_addr].
  - A transfer clears pending[addr].
  - Reserve and clear of the same register on the same edge: the set wins.
  - ZERO_REG bit is never set.
  - Reserve of an already-pending register leaves it set (no counting).
  - Write to a non-pending register is legal and leaves the bit 0.
- Hazards (combinational):
  - hazard_x = (pending[select_x] | (rf_write && rf_address==select_x)) && select_x!=ZERO_REG.
  - This covers the in-flight cycle between scoreboard clear and the register-file update.

Test Plan:
- Reset check: reset=0 with random inputs → all outputs 0, pending=32'h0. Release reset, then req0 and req1 both valid → req0_ready=1 and req1_ready=0 in the first cycle.
- Contention: hold both valid for 4 cycles (req0 addr 3, req1 addr 5) → grants alternate 0,1,0,1. The next 4 cycles show rf_write=1 with rf_address 3,5,3,5 and matching data.
- Latency: single req1 (addr 7, data 64'hDEADBEEF00000001) → rf_write=1, rf_address=7 and that data one cycle later. The register file reads r7 = that data one further cycle later.
- Scoreboard: reserve 9 → pending[9]=1 and hazard_a=1 with select_a=9. Writeback to 9 → pending[9] clears on the transfer edge, hazard_a stays 1 during the rf_write cycle, then drops to 0.
- Boundaries:
  - Reserve 9 and writeback 9 on the same edge → pending[9]=1.
  - Reserve 31 → pending=0.
  - req0 to addr 31 → ready=1 and rf_write stays 0.
- Asynchronous reset mid-stream: assert reset between edges while rf_write=1 and pending=32'h0000_0210 → outputs clear immediately without waiting for a clock edge.
